// File: rtl/io_ddr_pkg.sv
// io_ddr_pkg: implementation target selectors shared by the DDR pad blocks
package io_ddr_pkg;
    localparam TARGET_ALTERA  = "ALTERA";
    localparam TARGET_XILINX  = "XILINX";
    localparam TARGET_GENERIC = "GENERIC";
endpackage

// File: rtl/io_ddr_if.sv
// io_ddr_if: parallel side of the DDR pad (transmit word, receive word, drive enable)
interface io_ddr_if #(parameter int WIDTH = 8);
    logic [2*WIDTH-1:0] dat_i;
    logic [2*WIDTH-1:0] dat_o;
    logic               oe;
    modport master(output dat_i, oe, input dat_o);
    modport slave(input dat_i, oe, output dat_o);
endinterface

// File: rtl/io_ddr_generic.sv
// io_ddr_generic: behavioural DDR launch/capture with registered output enable
module io_ddr_generic #(parameter int WIDTH = 8) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inclk,
    input  logic [2*WIDTH-1:0] dat_i,
    input  logic               oe,
    output logic [2*WIDTH-1:0] dat_o,
    inout  wire  [WIDTH-1:0]   dq
);
    logic [WIDTH-1:0] out_h, out_l, in_h, in_l;
    logic             oe_q;
    always_ff @(posedge clk) begin
        out_h <= rst ? '0 : dat_i[2*WIDTH-1:WIDTH];
        out_l <= rst ? '0 : dat_i[WIDTH-1:0];
        oe_q  <= rst ? 1'b0 : oe;
    end
    // clk selects the half: high half in the high phase, low half in the low phase
    assign dq = oe_q ? (clk ? out_h : out_l) : {WIDTH{1'bz}};
    always_ff @(posedge inclk) begin
        in_h  <= rst ? '0 : dq;
        dat_o <= rst ? '0 : {in_h, in_l};
    end
    always_ff @(negedge inclk) in_l <= rst ? '0 : dq;
endmodule

// File: rtl/io_ddr.sv
// io_ddr: bidirectional DDR pad with per-target implementation selection
module io_ddr
    import io_ddr_pkg::*;
#(
    parameter     TARGET = TARGET_ALTERA,
    parameter int WIDTH  = 8
) (
    input logic            clk,
    input logic            rst,
    input logic            inclk,
    io_ddr_if.slave        bus,
    inout wire [WIDTH-1:0] dq
);
    // vendor DDIO cells are not wired in yet; each target maps to the cycle-identical generic model
    if (TARGET == TARGET_ALTERA) begin : g_altera
        io_ddr_generic #(.WIDTH(WIDTH)) u_ddr (
            .clk(clk), .rst(rst), .inclk(inclk),
            .dat_i(bus.dat_i), .oe(bus.oe), .dat_o(bus.dat_o), .dq(dq)
        );
    end else if (TARGET == TARGET_XILINX) begin : g_xilinx
        io_ddr_generic #(.WIDTH(WIDTH)) u_ddr (
            .clk(clk), .rst(rst), .inclk(inclk),
            .dat_i(bus.dat_i), .oe(bus.oe), .dat_o(bus.dat_o), .dq(dq)
        );
    end else begin : g_generic
        io_ddr_generic #(.WIDTH(WIDTH)) u_ddr (
            .clk(clk), .rst(rst), .inclk(inclk),
            .dat_i(bus.dat_i), .oe(bus.oe), .dat_o(bus.dat_o), .dq(dq)
        );
    end
endmodule

// File: tb/tb_io_ddr.sv
// tb_io_ddr: table-driven DDR pad bench with transmit/loopback scoreboards
module tb_io_ddr;
    typedef struct {
        logic [15:0] d;
        logic        oe;
        logic [7:0]  exp_h;
        logic [7:0]  exp_l;
    } vec_t;

    logic clk = 1'b0, clk_d = 1'b0, rst = 1'b1;
    logic drv_en = 1'b0, drv1_en = 1'b0;
    logic [7:0] drv = '0;
    logic       drv1 = 1'b0;
    wire  [7:0] dq8;
    wire  [0:0] dq1;
    int compared = 0, mismatched = 0;
    vec_t tbl[7];
    vec_t tx_q[$];
    logic [15:0] rx_q[$];
    vec_t cur;
    int lat;

    io_ddr_if #(.WIDTH(8)) b8();
    io_ddr_if #(.WIDTH(1)) b1();

    io_ddr #(.TARGET("ALTERA"), .WIDTH(8)) u8 (.clk(clk), .rst(rst), .inclk(clk_d), .bus(b8), .dq(dq8));
    io_ddr #(.TARGET("XILINX"), .WIDTH(1)) u1 (.clk(clk), .rst(rst), .inclk(clk_d), .bus(b1), .dq(dq1));

    assign dq8 = drv_en ? drv : 8'hzz;
    assign dq1 = drv1_en ? drv1 : 1'bz;

    always #10 clk = ~clk;
    // capture strobe sits a quarter period after clk so it samples mid-phase
    always @(posedge clk) begin #5 clk_d = 1'b1; end
    always @(negedge clk) begin #5 clk_d = 1'b0; end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // a released pad must follow whatever the bench drives onto it
    task automatic rel8(input string nm);
        drv_en = 1'b1; drv = 8'h55;
        #1 chk(nm, {8'h00, dq8}, 16'h0055);
        drv = 8'hAA;
        #1 chk(nm, {8'h00, dq8}, 16'h00AA);
        drv_en = 1'b0;
    endtask

    task automatic rel1(input string nm);
        drv1_en = 1'b1; drv1 = 1'b1;
        #1 chk(nm, {15'h0, dq1}, 16'h0001);
        drv1 = 1'b0;
        #1 chk(nm, {15'h0, dq1}, 16'h0000);
        drv1_en = 1'b0;
    endtask

    task automatic tx_chk(input string nm, input logic oe, input logic [7:0] e);
        if (oe) begin
            #1 chk(nm, {8'h00, dq8}, {8'h00, e});
            #1;
        end else rel8({nm, "_release"});
    endtask

    initial begin
        b8.dat_i = 16'hFFFF; b8.oe = 1'b1;
        b1.dat_i = 2'b11;    b1.oe = 1'b1;
        tbl = '{'{16'hA55A, 1'b1, 8'hA5, 8'h5A},
                '{16'h1234, 1'b1, 8'h12, 8'h34},
                '{16'hBEEF, 1'b1, 8'hBE, 8'hEF},
                '{16'h0000, 1'b0, 8'h00, 8'h00},
                '{16'hFFFF, 1'b1, 8'hFF, 8'hFF},
                '{16'h8001, 1'b1, 8'h80, 8'h01},
                '{16'h0F0F, 1'b0, 8'h00, 8'h00}};
        // reset with oe held high
        repeat (2) @(posedge clk);
        #2 rel8("rst_dq8");
        #3;
        chk("rst_dat_o8", b8.dat_o, 16'h0000);
        chk("rst_dat_o1", {14'h0, b1.dat_o}, 16'h0000);
        @(negedge clk); #2 rel1("rst_dq1");
        @(posedge clk); #1;
        rst = 1'b0; b8.oe = 1'b0; b1.oe = 1'b0; b8.dat_i = '0;
        // table: transmit phases and loopback words through scoreboards
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            lat = 0;
            if (i < 7) begin
                b8.dat_i = tbl[i].d; b8.oe = tbl[i].oe;
                tx_q.push_back(tbl[i]);
                lat = 1;
            end
            #1;
            if (tx_q.size() > lat) tx_chk("tx_h", tx_q[0].oe, tx_q[0].exp_h); else #2;
            #3;
            if (rx_q.size() > 0) chk("loopback", b8.dat_o, rx_q.pop_front());
            @(negedge clk); #2;
            if (tx_q.size() > lat) begin
                cur = tx_q.pop_front();
                tx_chk("tx_l", cur.oe, cur.exp_l);
                if (cur.oe) rx_q.push_back({cur.exp_h, cur.exp_l});
            end
        end
        chk("sb_drained", 16'(tx_q.size() + rx_q.size()), 16'h0000);
        // receive with pads released
        @(posedge clk); #1 drv_en = 1'b1; drv = 8'hC3;
        #1 chk("rx_pad_h", {8'h00, dq8}, 16'h00C3);
        @(negedge clk); #1 drv = 8'h3C;
        #1 chk("rx_pad_l", {8'h00, dq8}, 16'h003C);
        @(posedge clk); #1 drv_en = 1'b0;
        #6 chk("rx_word", b8.dat_o, 16'hC33C);
        // turnaround: drive, then release and take an external FF
        @(posedge clk); #1 b8.dat_i = 16'h0000; b8.oe = 1'b1;
        @(posedge clk); #2 chk("ta_drive", {8'h00, dq8}, 16'h0000);
        b8.oe = 1'b0;
        @(posedge clk); #2 rel8("ta_release");
        drv_en = 1'b1; drv = 8'hFF;
        #2 chk("ta_ext", {8'h00, dq8}, 16'h00FF);
        @(posedge clk); #7 chk("ta_capture", b8.dat_o, 16'hFFFF);
        drv_en = 1'b0;
        // single-pin instance, then reset mid-stream
        @(posedge clk); #1 b1.dat_i = 2'b10; b1.oe = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2 chk("w1_h", {15'h0, dq1}, 16'h0001);
            @(negedge clk); #2 chk("w1_l", {15'h0, dq1}, 16'h0000);
        end
        @(posedge clk); #7 chk("w1_rx", {14'h0, b1.dat_o}, 16'h0002);
        #1 rst = 1'b1;
        @(posedge clk); #2 rel8("rst_mid_dq8");
        rel1("rst_mid_dq1");
        #1;
        chk("rst_mid_dat_o1", {14'h0, b1.dat_o}, 16'h0000);
        chk("rst_mid_dat_o8", b8.dat_o, 16'h0000);
        @(posedge clk); #1 rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/io_ddr.md
Name: io_ddr

Overview:
- Parameterised bidirectional DDR pad interface for the HyperBus controller.
- One instance carries the DQ bus (WIDTH=8); a second carries RWDS (WIDTH=1).
- Transmit: a 2*WIDTH word per clk cycle is serialised onto WIDTH pins, one half per clock phase.
- Receive: both edges of a capture clock are sampled and the result is presented as a 2*WIDTH word.
- Output enable is registered, so pins can turn around between command/write and read phases.

Parameters:
- TARGET, "ALTERA", implementation selector. Allowed values: "ALTERA", "XILINX", "GENERIC".
  - "ALTERA" and "XILINX" may use vendor DDR primitives.
  - Any other value selects the behavioural generic model.
  - Cycle behaviour is identical for every value.
- WIDTH, 8, number of bidirectional pins (>=1).

Ports:
- clk  in  1  launch clock; all output-side registers use its rising edge.
- rst  in  1  synchronous, active-high reset.
- inclk  in  1  capture clock for dq, e.g. RWDS strobe, or clk for the RWDS instance.
- dat_i  in  2*WIDTH  transmit word; [2W-1:W] is sent first, [W-1:0] second.
- dat_o  out  2*WIDTH  received word; [2W-1:W] is rising-edge data, [W-1:0] is falling-edge data.
- dq  inout  WIDTH  pad pins.
- oe  in  1  drive enable: 1 = drive dq, 0 = tri-state.

Behaviour:
- Output path:
  - On posedge clk, register dat_i[2W-1:W] into out_h, dat_i[W-1:0] into out_l, and oe into oe_q.
  - dq = out_h while clk is high; dq = out_l while clk is low.
  - Latency: a word presented before posedge N appears on dq as the high half in the high phase after N, then the low half in the low phase. Repeat every cycle.
  - When oe_q = 0, dq is all 'z'.
  - oe takes effect one clk edge after sampling, aligned with the data launched at that edge.
- Input path:
  - On posedge inclk, capture dq into in_h.
  - On negedge inclk, capture dq into in_l.
  - On each posedge inclk, dat_o <= {in_h, in_l}, i.e. the pair from the previous full inclk period (previous rising edge, then falling edge).
  - dat_o changes only on posedge inclk.
  - Capture continues regardless of oe. With oe_q = 1 the block reads back its own driven data (loopback); the bench relies on this.
- Reset:
  - rst is synchronous. While rst is high at posedge clk: out_h and out_l clear to 0, and oe_q clears to 0 (pins released).
  - Capture registers and dat_o clear to 0 at any inclk edge where rst is high.
  - Reset mid-transfer: dq goes to 'z' within one clk edge, and dat_o is 0 by the next inclk rising edge.
  - Output values after reset: dq = 'z', dat_o = 0.
- Boundaries:
  - oe toggling every cycle must produce no glitch beyond one phase.
  - If inclk stops (e.g. RWDS idle), dat_o holds its last value.
  - 'z' or 'x' on dq is captured as-is in simulation.
- No handshake: the block is a pure pipeline and is always ready.

Decomposition:
- Shared package holds the TARGET string constants: TARGET_ALTERA, TARGET_XILINX, TARGET_GENERIC.
- Top io_ddr uses a generate on TARGET to choose the vendor primitive wrapper or the generic model.
- One sub-module, io_ddr_generic, contains the behavioural registers, phase mux and tri-state.
  - Vendor branches instantiate primitives directly in generate blocks.

Test Plan:
1. Reset: hold rst for 2 clk cycles with oe=1 -> dq = 'z' and dat_o = 0 after the first inclk rising edge.
2. Transmit, WIDTH=8: dat_i=16'hA55A then 16'h1234, oe=1 -> dq shows A5 (clk high), 5A (clk low), 12, 34 in successive phases, starting one clk edge after sampling.
3. Loopback, inclk=clk, oe=1, dat_i=16'hBEEF -> dat_o=16'hBEEF two rising edges after dat_i is sampled.
4. Receive, oe=0: external driver puts 8'hC3 at the inclk rise and 8'h3C at the fall -> dat_o=16'hC33C at the next inclk rise; dq not driven by the DUT.
5. Turnaround: oe 1->0 mid-stream -> dq 'z' from the next clk edge; an external drive of 8'hFF is then captured without contention ('x' never appears).
6. WIDTH=1, inclk=clk: dat_i=2'b10, oe=1 -> dq high then low each cycle; dat_o=2'b10. Asserting rst mid-stream gives dq 'z' and dat_o 2'b00.
